crt_recombine: RTL and testbench
================================

Name: crt_recombine

Overview:
- Final stage of the RSA CRT decryption path. Sits downstream of the Euclidean q-inverse block and the two half-size modular exponentiators.
- Consumes m1 = c^dp mod p, m2 = c^dq mod q and qinv = q^-1 mod p.
- Produces the plaintext m = m2 + q * ((qinv * (m1 - m2)) mod p) using Garner recombination.
- Bit-serial datapath, no hardware multiplier. Fixed latency; start/done handshake.

Parameters:
- W, 32, operand width of p, q, m1, m2, qinv. Result width is 2W.

Ports:
- clk  in  1  the single clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request, sampled on posedge clk when busy=0.
- p  in  W  prime p, must be nonzero.
- q  in  W  prime q.
- qinv  in  W  q^-1 mod p; precondition qinv < p.
- m1  in  W  precondition m1 < p.
- m2  in  W  precondition m2 < q; m2 >= p is allowed.
- m  out  2W  recombined plaintext, held until the next done.
- done  out  1  one-cycle pulse when m is valid.
- busy  out  1  high from the cycle after start is accepted until done.
- err  out  1  set with done when p==0; cleared on the next accepted start.

Behaviour:
- Reset: asynchronous, active-low. m=0, done=0, busy=0, err=0, state=IDLE, all internal registers cleared.
- Reset mid-operation aborts the computation. No done is produced.
- FSM states: IDLE, SUB, MMUL, MUL, FIN.
- IDLE: on start, latch p, q, qinv, m1, m2; set busy=1; clear err; go to SUB.
- start while busy=1 is ignored and the latched operands are unaffected.
- SUB, 1 cycle:
  - r = m2 mod p, using a combinational remainder.
  - d = (m1 >= r) ? m1 - r : m1 + p - r. Use W+1-bit intermediates; d < p.
  - Load acc=0 and bit counter i=W-1; go to MMUL.
  - If p==0: set err, m=0, go to FIN.
- MMUL, W cycles, interleaved MSB-first modular multiply:
  - acc' = 2*acc + (qinv[i] ? d : 0), with a W+2-bit accumulator.
  - Subtract p up to twice so that acc' < p.
  - Decrement i. After bit 0: h = acc, clear prod, go to MUL.
- MUL, W cycles, LSB-first shift-add h*q into a 2W-bit product.
  - After the last bit, go to FIN.
- FIN, 1 cycle:
  - m <= prod + zero-extended m2 (2W bits; cannot overflow because the result is < p*q).
  - done=1 for this cycle only; busy=0; go to IDLE.
  - A start in the FIN cycle is ignored; start is accepted from IDLE only.
- Latency: done is high exactly 2W+2 cycles after the edge that accepted start (66 cycles for W=32). For p==0, done is high 2 cycles after that edge.
- m, done and err are registered outputs, with no combinational path from the inputs.
- Inputs are read only at the accept edge; later input changes have no effect.
- Results for precondition violations other than p==0 are undefined but must not hang the FSM; it always returns to IDLE.

Test Plan:
- W=32, p=61, q=53, qinv=38, m1=4, m2=12 (M=65) -> d=53, h=1, m=65, done after exactly 66 cycles, err=0.
- p=61, q=53, qinv=38, m1=60, m2=52 (M=3232) -> h=60, m=3232.
- p=53, q=61, qinv=20, m1=7, m2=60 (m2 >= p path) -> r=7, d=0, m=60.
- p=0 with any other operands -> done after 2 cycles, err=1, m=0. A following valid start clears err.
- Mid-MMUL: pulse start again -> ignored, result still correct. Assert rst_n=0 mid-MUL -> m=0, busy=0, no done. A fresh start afterwards gives the correct result.
- 1000 random 32-bit prime pairs with qinv from a reference model and random M < p*q -> m==M every time, latency constant at 66, done always a single-cycle pulse.

Source files
------------

// File: rtl/crt_recombine.sv
// Garner CRT recombination for RSA decryption:
//   m = m2 + q * ((qinv * (m1 - m2)) mod p)
// Bit-serial datapath: one cycle of modular subtraction, W cycles of
// interleaved modular multiply, W cycles of shift-add multiply, one cycle
// to add m2 and publish the result.
module crt_recombine #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] p,
    input  logic [W-1:0] q,
    input  logic [W-1:0] qinv,
    input  logic [W-1:0] m1,
    input  logic [W-1:0] m2,
    output logic [2*W-1:0] m,
    output logic         done,
    output logic         busy,
    output logic         err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {IDLE, SUB, MMUL, MUL, FIN} state_t;

    state_t          state;
    logic [W-1:0]    p_r, q_r, qinv_r, m1_r, m2_r;
    logic [W-1:0]    d;        // (m1 - m2) mod p
    logic [W+1:0]    acc;      // modular-multiply accumulator, kept < p
    logic [W-1:0]    hsh;      // h, shifted right as the multiplier
    logic [2*W-1:0]  qsh;      // q, shifted left as the multiplicand
    logic [2*W-1:0]  prod;
    logic [CW-1:0]   cnt;
    logic            pzero;    // p == 0 seen in SUB; reported at FIN

    // SUB-cycle arithmetic: reduce m2 into [0,p) and form d = (m1 - r) mod p
    logic [W-1:0]    r;
    logic [W:0]      dwrap;
    logic [W-1:0]    d_nxt;
    always_comb begin
        r     = (p_r == '0) ? '0 : (m2_r % p_r);
        dwrap = {1'b0, m1_r} + {1'b0, p_r} - {1'b0, r};
        d_nxt = (m1_r >= r) ? (m1_r - r) : dwrap[W-1:0];
    end

    // One MSB-first step of qinv*d mod p: double, add, then at most two
    // conditional subtractions bring the sum back below p
    logic [W+1:0]    pw, t0, t1, acc_nxt;
    always_comb begin
        pw      = {2'b00, p_r};
        t0      = {acc[W:0], 1'b0} + (qinv_r[cnt] ? {2'b00, d} : '0);
        t1      = (t0 >= pw) ? (t0 - pw) : t0;
        acc_nxt = (t1 >= pw) ? (t1 - pw) : t1;
    end

    // Control FSM and datapath registers; outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            p_r    <= '0;
            q_r    <= '0;
            qinv_r <= '0;
            m1_r   <= '0;
            m2_r   <= '0;
            d      <= '0;
            acc    <= '0;
            hsh    <= '0;
            qsh    <= '0;
            prod   <= '0;
            cnt    <= '0;
            pzero  <= 1'b0;
            m      <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p_r    <= p;
                        q_r    <= q;
                        qinv_r <= qinv;
                        m1_r   <= m1;
                        m2_r   <= m2;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    d     <= d_nxt;
                    acc   <= '0;
                    cnt   <= CW'(W - 1);
                    pzero <= (p_r == '0);
                    state <= (p_r == '0) ? FIN : MMUL;
                end
                MMUL: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        hsh   <= acc_nxt[W-1:0];
                        qsh   <= {{W{1'b0}}, q_r};
                        prod  <= '0;
                        cnt   <= CW'(W - 1);
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (hsh[0]) prod <= prod + qsh;
                    hsh <= hsh >> 1;
                    qsh <= qsh << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIN;
                end
                FIN: begin
                    m     <= pzero ? '0 : (prod + {{W{1'b0}}, m2_r});
                    err   <= pzero;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crt_recombine.sv
// Bench for crt_recombine: directed Garner cases, p==0, ignored restart,
// mid-run reset, and random prime pairs checked against an arithmetic model.
module tb_crt_recombine;

    localparam int W   = 32;
    localparam int LAT = 2*W + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  p = '0, q = '0, qinv = '0, m1 = '0, m2 = '0;
    logic [2*W-1:0] m;
    logic          done, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    crt_recombine #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .p(p), .q(q), .qinv(qinv), .m1(m1), .m2(m2),
        .m(m), .done(done), .busy(busy), .err(err)
    );

    // ---------------- reference arithmetic ----------------
    function automatic longint unsigned mulmod(longint unsigned a, longint unsigned b,
                                               longint unsigned n);
        return (a * b) % n;   // a,b < n < 2^32, product fits in 64 bits
    endfunction

    function automatic longint unsigned powmod(longint unsigned b, longint unsigned e,
                                               longint unsigned n);
        longint unsigned res = 1;
        b = b % n;
        while (e != 0) begin
            if (e[0]) res = mulmod(res, b, n);
            b = mulmod(b, b, n);
            e = e >> 1;
        end
        return res;
    endfunction

    // Deterministic Miller-Rabin for n < 2^32 (bases 2, 7, 61)
    function automatic bit is_prime(longint unsigned n);
        longint unsigned dd, x;
        longint unsigned bases[3] = '{2, 7, 61};
        int s;
        bit comp;
        if (n < 2) return 0;
        if (n % 2 == 0) return (n == 2);
        dd = n - 1; s = 0;
        while (dd % 2 == 0) begin dd = dd / 2; s++; end
        foreach (bases[k]) begin
            if (bases[k] % n == 0) continue;
            x = powmod(bases[k], dd, n);
            if (x == 1 || x == n - 1) continue;
            comp = 1;
            for (int j = 1; j < s; j++) begin
                x = mulmod(x, x, n);
                if (x == n - 1) begin comp = 0; break; end
            end
            if (comp) return 0;
        end
        return 1;
    endfunction

    function automatic longint unsigned rand_prime();
        longint unsigned c;
        do c = {32'h0, ($urandom() | 32'h8000_0001)}; while (!is_prime(c));
        return c;
    endfunction

    // Modular inverse by extended Euclid
    function automatic longint unsigned modinv(longint unsigned a, longint unsigned n);
        longint r0 = longint'(n), r1 = longint'(a % n);
        longint t0 = 0, t1 = 1, qt, tmp;
        while (r1 != 0) begin
            qt = r0 / r1;
            tmp = r0 - qt * r1; r0 = r1; r1 = tmp;
            tmp = t0 - qt * t1; t0 = t1; t1 = tmp;
        end
        if (t0 < 0) t0 = t0 + longint'(n);
        return longint'(t0);
    endfunction

    // ---------------- stimulus helper ----------------
    // Drives one request, scrambles the inputs after the accept edge, and
    // reports the result, done latency (-1 on timeout) and done one cycle later.
    task automatic run_op(input logic [W-1:0] pp, qq, qi, a, b,
                          output logic [2*W-1:0] rm, output logic re,
                          output int lat, output logic done_after);
        @(negedge clk);
        p = pp; q = qq; qinv = qi; m1 = a; m2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        p = $urandom(); q = $urandom(); qinv = $urandom(); m1 = $urandom(); m2 = $urandom();
        lat = -1;
        for (int k = 1; k <= 4*LAT; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        rm = m; re = err;
        @(posedge clk); #1;
        done_after = done;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({m, done, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset: m=%0h done=%b busy=%b err=%b, required all zero", m, done, busy, err);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] tp[3] = '{61, 61, 53};
        logic [W-1:0] tq[3] = '{53, 53, 61};
        logic [W-1:0] ti[3] = '{38, 38, 20};
        logic [W-1:0] ta[3] = '{4, 60, 7};
        logic [W-1:0] tb[3] = '{12, 52, 60};
        logic [2*W-1:0] exp_m[3] = '{65, 3232, 60};
        logic [2*W-1:0] rm; logic re, da; int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(tp[i], tq[i], ti[i], ta[i], tb[i], rm, re, lat, da);
            n_checks++;
            if (rm !== exp_m[i]) begin n_fail++; $display("FAIL directed%0d_m: got %0d, required %0d", i, rm, exp_m[i]); end
            n_checks++;
            if (lat != LAT) begin n_fail++; $display("FAIL directed%0d_latency: got %0d, required %0d", i, lat, LAT); end
            n_checks++;
            if (re !== 1'b0) begin n_fail++; $display("FAIL directed%0d_err: got %b, required 0", i, re); end
            n_checks++;
            if (da !== 1'b0) begin n_fail++; $display("FAIL directed%0d_pulse: done still high next cycle", i); end
        end
    endtask

    task automatic test_p_zero();
        logic [2*W-1:0] rm; logic re, da; int lat;
        run_op('0, 53, 38, 4, 12, rm, re, lat, da);
        n_checks++;
        if (lat != 2) begin n_fail++; $display("FAIL pzero_latency: got %0d, required 2", lat); end
        n_checks++;
        if (re !== 1'b1) begin n_fail++; $display("FAIL pzero_err: got %b, required 1", re); end
        n_checks++;
        if (rm !== '0) begin n_fail++; $display("FAIL pzero_m: got %0h, required 0", rm); end
        // err must drop as soon as the next valid request is accepted
        @(negedge clk);
        p = 61; q = 53; qinv = 38; m1 = 60; m2 = 52; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL pzero_clear: err=%b busy=%b, required err=0 busy=1", err, busy);
        end
        repeat (LAT + 2) @(posedge clk);
        #1;
        n_checks++;
        if (m !== 64'd3232 || err !== 1'b0) begin
            n_fail++; $display("FAIL pzero_recover: m=%0d err=%b, required 3232 and 0", m, err);
        end
    endtask

    task automatic test_restart_ignored();
        int lat = -1;
        @(negedge clk);
        p = 61; q = 53; qinv = 38; m1 = 4; m2 = 12; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        p = 53; q = 61; qinv = 20; m1 = 7; m2 = 60; start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 12; k <= 4*LAT; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL restart_latency: got %0d, required %0d", lat, LAT); end
        n_checks++;
        if (m !== 64'd65) begin n_fail++; $display("FAIL restart_m: got %0d, required 65", m); end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] rm; logic re, da; int lat;
        bit seen = 0;
        @(negedge clk);
        p = 61; q = 53; qinv = 38; m1 = 60; m2 = 52; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (W + 8) @(posedge clk);   // well inside the shift-add phase
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (m !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midreset: m=%0h busy=%b done=%b, required 0/0/0", m, busy, done);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < LAT + 10; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midreset_nodone: got done=1, required none"); end
        run_op(61, 53, 38, 60, 52, rm, re, lat, da);
        n_checks++;
        if (rm !== 64'd3232 || lat != LAT) begin
            n_fail++; $display("FAIL midreset_fresh: m=%0d lat=%0d, required 3232 and %0d", rm, lat, LAT);
        end
    endtask

    task automatic test_random(input int n);
        longint unsigned rp, rq, pq, big, qi;
        logic [2*W-1:0] rm; logic re, da; int lat;
        for (int i = 0; i < n; i++) begin
            rp = rand_prime();
            do rq = rand_prime(); while (rq == rp);
            qi = modinv(rq, rp);
            pq = rp * rq;
            big = {$urandom(), $urandom()};
            big = big % pq;
            run_op(rp[W-1:0], rq[W-1:0], qi[W-1:0], W'(big % rp), W'(big % rq), rm, re, lat, da);
            n_checks++;
            if (rm !== big) begin n_fail++; $display("FAIL random%0d_m: got %0h, required %0h (p=%0h q=%0h)", i, rm, big, rp, rq); end
            n_checks++;
            if (lat != LAT || re !== 1'b0) begin n_fail++; $display("FAIL random%0d_latency_err: lat=%0d err=%b, required %0d and 0", i, lat, re, LAT); end
            n_checks++;
            if (da !== 1'b0) begin n_fail++; $display("FAIL random%0d_pulse: done high for more than one cycle", i); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_p_zero();
        test_restart_ignored();
        test_reset_mid();
        test_random(1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
